// File: rtl/calc_input_ctrl_pkg.sv
// Shared types and constants for the calculator input controller.
// Holds the capture FSM state encoding and the function-select width.
package calc_input_ctrl_pkg;

    localparam int FUNC_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/calc_input_ctrl_key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter
// and a registered one-cycle press (1->0) pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync1_d;
    logic          sync2_q;
    logic          sync2_d;
    logic          stable_q;
    logic          stable_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        // Flip only after the input has differed for a full window.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                press_d  = stable_q & ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/calc_input_ctrl.sv
// Captures switch operands on a debounced load press and offers
// them downstream with a valid/ready handshake; clear press zeroes.
module calc_input_ctrl
    import calc_input_ctrl_pkg::*;
#(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  sw_a,
    input  logic [WIDTH-1:0]  sw_b,
    input  logic [FUNC_W-1:0] sw_func,
    input  logic              key_load_n,
    input  logic              key_clr_n,
    output logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  b,
    output logic [FUNC_W-1:0] func,
    output logic              valid,
    input  logic              ready,
    output logic              loaded
);

    logic load_press;
    logic clr_press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_db (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_load_n),
        .press(load_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr_db (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_clr_n),
        .press(clr_press)
    );

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  a_d;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  b_d;
    logic [FUNC_W-1:0] func_q;
    logic [FUNC_W-1:0] func_d;
    logic              capture;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        // Clear has priority over any load press on the same edge.
        if (clr_press) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_press) begin
                        capture = 1'b1;
                        state_d = OFFER;
                    end
                end
                OFFER: begin
                    if (ready) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (load_press) begin
                        capture = 1'b1;
                        state_d = OFFER;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        func_d = func_q;
        if (clr_press) begin
            a_d    = '0;
            b_d    = '0;
            func_d = '0;
        end else if (capture) begin
            a_d    = sw_a;
            b_d    = sw_b;
            func_d = sw_func;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            func_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            func_q  <= func_d;
        end
    end

    assign a      = a_q;
    assign b      = b_q;
    assign func   = func_q;
    assign valid  = (state_q == OFFER);
    assign loaded = (state_q == HOLD);

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Scoreboard bench for calc_input_ctrl with a short debounce window.
module tb_calc_input_ctrl;

    localparam int W = 6;
    localparam int N = 4;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   f;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] sw_a;
    logic [W-1:0] sw_b;
    logic [2:0]   sw_func;
    logic         key_load_n;
    logic         key_clr_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   func;
    logic         valid;
    logic         ready;
    logic         loaded;

    calc_input_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_a(sw_a),
        .sw_b(sw_b),
        .sw_func(sw_func),
        .key_load_n(key_load_n),
        .key_clr_n(key_clr_n),
        .a(a),
        .b(b),
        .func(func),
        .valid(valid),
        .ready(ready),
        .loaded(loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   vcyc   = 0;
    int   caps   = 0;
    logic valid_d = 1'b0;
    exp_t sb[$];
    exp_t e;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Output side of the scoreboard: each new offer pops one entry.
    always @(negedge clk) begin
        if (rst_n && valid) vcyc++;
        if (rst_n && valid && !valid_d) begin
            caps++;
            if (sb.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_a", 32'(a), 32'(e.a));
                chk("sb_b", 32'(b), 32'(e.b));
                chk("sb_func", 32'(func), 32'(e.f));
            end
        end
        valid_d = valid;
    end

    task automatic set_sw(input int va, input int vb, input int vf);
        sw_a    = W'(va);
        sw_b    = W'(vb);
        sw_func = 3'(vf);
    endtask

    task automatic press_load(input int n);
        key_load_n = 1'b0;
        repeat (n) @(negedge clk);
        key_load_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    int c0;
    int v0;

    initial begin
        rst_n      = 1'b0;
        key_load_n = 1'b1;
        key_clr_n  = 1'b1;
        ready      = 1'b0;
        set_sw(0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_a", 32'(a), 0);
        chk("rst_b", 32'(b), 0);
        chk("rst_func", 32'(func), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_loaded", 32'(loaded), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Held load press: valid first seen after edge N+3.
        set_sw(5, 3, 1);
        sb.push_back('{a: 6'd5, b: 6'd3, f: 3'd1});
        key_load_n = 1'b0;
        repeat (N + 2) @(negedge clk);
        chk("lat_pre", 32'(valid), 0);
        @(negedge clk);
        chk("lat_valid", 32'(valid), 1);
        chk("lat_a", 32'(a), 5);
        key_load_n = 1'b1;
        repeat (8) @(negedge clk);

        // OFFER stalled: new switches and a load press are ignored.
        set_sw(9, 9, 2);
        press_load(10);
        repeat (2) @(negedge clk);
        chk("stall_valid", 32'(valid), 1);
        chk("stall_a", 32'(a), 5);
        chk("stall_b", 32'(b), 3);
        chk("stall_func", 32'(func), 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("hs_valid", 32'(valid), 0);
        chk("hs_loaded", 32'(loaded), 1);

        // Clear and load on the same edge: clear wins.
        key_load_n = 1'b0;
        key_clr_n  = 1'b0;
        repeat (10) @(negedge clk);
        key_load_n = 1'b1;
        key_clr_n  = 1'b1;
        repeat (8) @(negedge clk);
        chk("clr_a", 32'(a), 0);
        chk("clr_b", 32'(b), 0);
        chk("clr_func", 32'(func), 0);
        chk("clr_valid", 32'(valid), 0);
        chk("clr_loaded", 32'(loaded), 0);

        // Bouncy key never reaches a stable low.
        set_sw(7, 4, 2);
        c0 = caps;
        key_load_n = 1'b0;
        repeat (2) @(negedge clk);
        key_load_n = 1'b1;
        @(negedge clk);
        key_load_n = 1'b0;
        repeat (2) @(negedge clk);
        key_load_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("bounce_valid", 32'(valid), 0);
        chk("bounce_a", 32'(a), 0);
        sb.push_back('{a: 6'd7, b: 6'd4, f: 3'd2});
        press_load(10);
        chk("bounce_caps", caps - c0, 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("bounce_loaded", 32'(loaded), 1);

        // Ready already high: single-cycle valid.
        ready = 1'b1;
        set_sw(63, 0, 7);
        sb.push_back('{a: 6'd63, b: 6'd0, f: 3'd7});
        v0 = vcyc;
        press_load(10);
        chk("rdy_vcyc", vcyc - v0, 1);
        chk("rdy_a", 32'(a), 63);
        chk("rdy_b", 32'(b), 0);
        chk("rdy_func", 32'(func), 7);
        chk("rdy_loaded", 32'(loaded), 1);
        ready = 1'b0;

        // Reset mid-OFFER with the key held low.
        set_sw(10, 20, 3);
        sb.push_back('{a: 6'd10, b: 6'd20, f: 3'd3});
        key_load_n = 1'b0;
        repeat (N + 3) @(negedge clk);
        chk("pre_rst_valid", 32'(valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a", 32'(a), 0);
        chk("arst_b", 32'(b), 0);
        chk("arst_func", 32'(func), 0);
        chk("arst_valid", 32'(valid), 0);
        repeat (2) @(negedge clk);
        set_sw(11, 21, 4);
        sb.push_back('{a: 6'd11, b: 6'd21, f: 3'd4});
        rst_n = 1'b1;
        repeat (N + 2) @(negedge clk);
        chk("post_rst_pre", 32'(valid), 0);
        @(negedge clk);
        chk("post_rst_valid", 32'(valid), 1);
        chk("post_rst_a", 32'(a), 11);
        key_load_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
